fp16_rnorm_round: RTL

- Multi-cycle normalize-and-round back end for the FP16 relaxed add/sub pipeline.
- Consumes the unnormalized sign/exponent/21-bit magnitude that the add/sub stages produce, including the case where subtraction leaves leading zeros.
- Shifts out leading zeros, applies round-to-nearest-even, and packs an IEEE binary16 word.
- Valid/ready on both sides; one operation in flight at a time.

---
 rtl/fp16_rnorm_round_if.sv | 22 ++
 rtl/fp16_rnorm_round.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fp16_rnorm_round_if.sv
// Handshake and data bundle between the FP16 add/sub front end and the
// normalize/round back end.
interface fp16_rnorm_round_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [4:0]  in_exp;
   logic [20:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fp16_rnorm_round.sv
// Multi-cycle normalize and round-to-nearest-even back end for the FP16
// add/sub pipeline; one operation in flight, valid/ready on both sides.
module fp16_rnorm_round #(
   parameter int unsigned SHIFT_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   fp16_rnorm_round_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t      state, state_nxt;
   logic        s, s_nxt;
   logic [5:0]  e, e_nxt;
   logic [20:0] m, m_nxt;
   logic [15:0] data, data_nxt;
   logic        valid, valid_nxt;

   logic [20:0] sh_m;
   logic [5:0]  sh_e;
   logic [11:0] rnd;
   logic [5:0]  ef;
   logic [9:0]  frac;
   logic        up;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = valid;
   assign bus.out_data  = data;

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      e_nxt     = e;
      m_nxt     = m;
      data_nxt  = data;
      valid_nxt = 1'b0;
      sh_m      = m;
      sh_e      = e;
      rnd       = '0;
      ef        = '0;
      frac      = '0;
      up        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               s_nxt = bus.in_sign;
               m_nxt = bus.in_mant;
               e_nxt = (bus.in_exp == 5'd0) ? 6'd1 : {1'b0, bus.in_exp};
               if (bus.in_exp == 5'h1F) begin
                  // A NaN whose payload sits only in the round bits must stay a NaN
                  frac = bus.in_mant[19:10];
                  if (frac == '0 && |bus.in_mant[9:0])
                     frac = 10'h200;
                  data_nxt  = {bus.in_sign, 5'h1F, frac};
                  state_nxt = DONE;
               end else if (bus.in_mant == '0) begin
                  data_nxt  = {bus.in_sign, 15'h0000};
                  state_nxt = DONE;
               end else begin
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
               if (!sh_m[20] && sh_e > 6'd1) begin
                  sh_m = {sh_m[19:0], 1'b0};
                  sh_e = sh_e - 6'd1;
               end
            end
            m_nxt = sh_m;
            e_nxt = sh_e;
            if (sh_m[20] || sh_e == 6'd1)
               state_nxt = ROUND;
         end
         ROUND: begin
            up  = m[9] & ((|m[8:0]) | m[10]);
            rnd = {1'b0, m[20:10]} + {11'b0, up};
            if (rnd[11]) begin
               frac = '0;
               ef   = e + 6'd1;
            end else if (rnd[10]) begin
               frac = rnd[9:0];
               ef   = e;
            end else begin
               frac = rnd[9:0];
               ef   = '0;
            end
            data_nxt  = (ef >= 6'd31) ? {s, 5'h1F, 10'h000} : {s, ef[4:0], frac};
            state_nxt = DONE;
         end
         DONE: begin
            // out_valid is registered, so it rises one edge after DONE is entered
            valid_nxt = ~(valid & bus.out_ready);
            if (valid & bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         s     <= 1'b0;
         e     <= '0;
         m     <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         e     <= e_nxt;
         m     <= m_nxt;
         data  <= data_nxt;
         valid <= valid_nxt;
      end
   end

endmodule
